// File: rtl/dmem_resp_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds FSM state encodings, address-map defaults and the byte-lane merge helper.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_t;

    localparam logic [31:0] DMEM_MMIO_BASE = 32'h0000_8000;
    localparam int          DMEM_NUM_OBS   = 10;

    // Replace each byte lane of old_word whose strobe bit is set.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with synchronous byte-enable write and combinational read.
// Contents are deliberately not reset.
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one outstanding request, fixed wait states, RAM plus observation registers.
// Response appears LATENCY+1 cycles after the accept cycle and is held until rsp_ready.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] MMIO_BASE   = DMEM_MMIO_BASE,
    parameter int          NUM_OBS     = DMEM_NUM_OBS
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] data1,
    output logic [31:0] data2,
    output logic [31:0] data3,
    output logic [31:0] data4,
    output logic [31:0] data5,
    output logic [31:0] data6,
    output logic [31:0] data7,
    output logic [31:0] data8,
    output logic [31:0] data9,
    output logic [31:0] data10
);

    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [31:0] DEPTH_U  = 32'(DEPTH_WORDS);
    localparam logic [31:0] OBS_END  = MMIO_BASE + 32'(4 * NUM_OBS);

    dmem_state_t state, state_nxt;
    logic [3:0]  cnt;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;

    logic        accept;
    logic        do_access;
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wstrb;

    logic        misal;
    logic        obs_hit;
    logic        ram_hit;
    logic        acc_err;
    logic [31:0] obs_off;
    logic [31:0] obs_rd;
    logic [31:0] rd_next;
    logic        ram_we;
    logic [31:0] ram_rdata;

    logic [31:0] obs [NUM_OBS];

    assign req_ready = (state == DMEM_IDLE);
    assign rsp_valid = (state == DMEM_RESP);
    assign accept    = req_valid && req_ready;

    // With zero wait states the access happens on the accept edge itself, so
    // the live request fields are used instead of the (not yet loaded) latch.
    assign do_access = (accept && (LATENCY == 0)) ||
                       ((state == DMEM_WAIT) && (cnt == 4'd0));
    assign cur_we    = (state == DMEM_IDLE) ? req_we    : lat_we;
    assign cur_addr  = (state == DMEM_IDLE) ? req_addr  : lat_addr;
    assign cur_wdata = (state == DMEM_IDLE) ? req_wdata : lat_wdata;
    assign cur_wstrb = (state == DMEM_IDLE) ? req_wstrb : lat_wstrb;

    always_comb begin
        state_nxt = state;
        case (state)
            DMEM_IDLE: begin
                if (req_valid) begin
                    state_nxt = (LATENCY == 0) ? DMEM_RESP : DMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = DMEM_RESP;
                end
            end
            DMEM_RESP: begin
                if (rsp_ready) begin
                    state_nxt = DMEM_IDLE;
                end
            end
            default: state_nxt = DMEM_IDLE;
        endcase
    end

    // Address decode; misalignment outranks every mapped region.
    always_comb begin
        misal   = |cur_addr[1:0];
        obs_off = cur_addr - MMIO_BASE;
        obs_hit = (cur_addr >= MMIO_BASE) && (cur_addr < OBS_END);
        ram_hit = (32'(cur_addr[31:2]) < DEPTH_U);
        acc_err = misal || !(obs_hit || ram_hit);
        obs_rd  = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (obs_off[31:2] == 30'(i)) begin
                obs_rd = obs[i];
            end
        end
        rd_next = '0;
        if (!acc_err && !cur_we) begin
            rd_next = obs_hit ? obs_rd : ram_rdata;
        end
        ram_we = do_access && cur_we && !acc_err && !obs_hit;
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (cur_addr[IDX_W+1:2]),
        .wdata (cur_wdata),
        .wstrb (cur_wstrb),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= DMEM_IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wstrb <= req_wstrb;
                cnt       <= LAT_INIT;
            end else if ((state == DMEM_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                rsp_rdata <= rd_next;
                rsp_err   <= acc_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                obs[i] <= '0;
            end
        end else if (do_access && cur_we && !misal && obs_hit) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                if (obs_off[31:2] == 30'(i)) begin
                    obs[i] <= merge_bytes(obs[i], cur_wdata, cur_wstrb);
                end
            end
        end
    end

    assign data1  = obs[0];
    assign data2  = obs[1];
    assign data3  = obs[2];
    assign data4  = obs[3];
    assign data5  = obs[4];
    assign data6  = obs[5];
    assign data7  = obs[6];
    assign data8  = obs[7];
    assign data9  = obs[8];
    assign data10 = obs[9];

endmodule
